// File: rtl/axi_lite_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_arb_pkg
//  Description : Shared definitions for the AXI4-Lite request arbiter:
//                FSM state encodings, AXI response codes and a constant
//                clog2 helper for index/pointer/counter widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_arb_pkg;

  // Arbiter FSM state encodings
  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_busy = 2'd1;
  localparam logic [1:0] c_resp = 2'd2;

  // AXI RRESP/BRESP encodings. The master collapses any non-OKAY response
  // into m_err; a watchdog abort is reported as SLVERR.
  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_req_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_req_arbiter_if
//  Description : Bundles the requester-side and downstream-master-side
//                signals of the AXI4-Lite request arbiter.
//                  master : arbiter view (drives grants, responses, m_*)
//                  slave  : environment view (requesters + downstream master)
//  Ports       : req_valid/req_write/req_addr/req_wdata (requests),
//                req_ready/resp_valid/resp_rdata/resp_err (per-requester
//                handshake), m_rd_req/m_wr_req/m_addr/m_wdata/m_abort and
//                m_rdata/m_done/m_err (downstream transaction port)
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_lite_req_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*32-1:0]         req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_rdata;
  logic                          resp_err;

  logic                          m_rd_req;
  logic                          m_wr_req;
  logic [31:0]                   m_addr;
  logic [DATA_WIDTH-1:0]         m_wdata;
  logic [DATA_WIDTH-1:0]         m_rdata;
  logic                          m_done;
  logic                          m_err;
  logic                          m_abort;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  m_rdata, m_done, m_err,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output m_rd_req, m_wr_req, m_addr, m_wdata, m_abort
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output m_rdata, m_done, m_err,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  m_rd_req, m_wr_req, m_addr, m_wdata, m_abort
  );

endinterface
`default_nettype wire

// File: rtl/axi_lite_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_rr_pick
//  Description : Combinational round-robin picker. Returns the first set
//                request bit found scanning upward from i_rr_ptr, wrapping
//                modulo NUM_REQ.
//  Ports       : i_req     - request vector
//                i_rr_ptr  - highest-priority index
//                o_winner  - selected index (0 when no request)
//                o_any_req - at least one request bit set
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_rr_pick
  import axi_lite_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  wire logic [NUM_REQ-1:0]        i_req,
  input  wire logic [clog2(NUM_REQ)-1:0] i_rr_ptr,
  output logic      [clog2(NUM_REQ)-1:0] o_winner,
  output logic                           o_any_req
);

  localparam int IDX_W = clog2(NUM_REQ);

  // One spare bit so ptr + offset can exceed NUM_REQ-1 before wrapping.
  logic [IDX_W:0] w_idx;

  always_comb begin
    o_winner  = '0;
    o_any_req = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, i_rr_ptr} + (IDX_W + 1)'(k);
      if (w_idx >= (IDX_W + 1)'(NUM_REQ)) w_idx = w_idx - (IDX_W + 1)'(NUM_REQ);
      if (!o_any_req && i_req[w_idx[IDX_W-1:0]]) begin
        o_any_req = 1'b1;
        o_winner  = w_idx[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_lite_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_req_arbiter
//  Description : Shares one AXI4-Lite master transaction port among NUM_REQ
//                requesters. Round-robin accepts one request, holds it on
//                the master port until m_done (or watchdog expiry), then
//                returns a one-cycle response to the winner.
//  Ports       : clk   - clock
//                reset - synchronous, active-low reset
//                bus   - axi_lite_req_arbiter_if.master (requester handshake
//                        and downstream master port)
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_req_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input wire logic clk,
  input wire logic reset,
  axi_lite_req_arbiter_if.master bus
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int CNT_W = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_tlast = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [1:0]            r_state;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [IDX_W-1:0]      r_winner;
  logic [CNT_W-1:0]      r_tcnt;

  logic [NUM_REQ-1:0]    r_req_ready;
  logic [NUM_REQ-1:0]    r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_resp_err;
  logic                  r_m_rd_req;
  logic                  r_m_wr_req;
  logic [31:0]           r_m_addr;
  logic [DATA_WIDTH-1:0] r_m_wdata;
  logic                  r_m_abort;

  logic [IDX_W-1:0]      w_winner;
  logic                  w_any_req;
  logic [31:0]           w_addr_sel;
  logic [DATA_WIDTH-1:0] w_wdata_sel;
  logic [1:0]            w_resp_code;
  logic [IDX_W-1:0]      w_next_ptr;

  axi_lite_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_req     (bus.req_valid),
    .i_rr_ptr  (r_rr_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  // Mux the winner's slice out of the flat address/data buses.
  always_comb begin
    w_addr_sel  = '0;
    w_wdata_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == IDX_W'(i)) begin
        w_addr_sel  = bus.req_addr[32*i +: 32];
        w_wdata_sel = bus.req_wdata[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  assign w_resp_code = bus.m_err ? c_resp_slverr : c_resp_okay;
  assign w_next_ptr  = (r_winner == IDX_W'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= c_idle;
      r_rr_ptr     <= '0;
      r_winner     <= '0;
      r_tcnt       <= '0;
      r_req_ready  <= '0;
      r_resp_valid <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_m_rd_req   <= 1'b0;
      r_m_wr_req   <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_m_abort    <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one cycle.
      r_req_ready  <= '0;
      r_resp_valid <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_m_abort    <= 1'b0;

      case (r_state)
        c_idle: begin
          if (w_any_req) begin
            r_state     <= c_busy;
            r_winner    <= w_winner;
            r_tcnt      <= '0;
            r_m_wr_req  <= bus.req_write[w_winner];
            r_m_rd_req  <= ~bus.req_write[w_winner];
            r_m_addr    <= w_addr_sel;
            r_m_wdata   <= w_wdata_sel;
            r_req_ready <= NUM_REQ'(1) << w_winner;
          end
        end

        c_busy: begin
          r_tcnt <= r_tcnt + 1'b1;
          if (bus.m_done) begin
            // Completion takes priority over a coincident watchdog expiry.
            r_state      <= c_resp;
            r_resp_valid <= NUM_REQ'(1) << r_winner;
            r_resp_rdata <= r_m_wr_req ? '0 : bus.m_rdata;
            r_resp_err   <= (w_resp_code != c_resp_okay);
            r_m_rd_req   <= 1'b0;
            r_m_wr_req   <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
          end else if (TIMEOUT != 0 && r_tcnt == c_tlast) begin
            r_state      <= c_resp;
            r_resp_valid <= NUM_REQ'(1) << r_winner;
            r_resp_err   <= 1'b1;
            r_m_abort    <= 1'b1;
            r_m_rd_req   <= 1'b0;
            r_m_wr_req   <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
          end
        end

        c_resp: begin
          r_state  <= c_idle;
          r_rr_ptr <= w_next_ptr;
          r_tcnt   <= '0;
        end

        default: r_state <= c_idle;
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.m_rd_req   = r_m_rd_req;
  assign bus.m_wr_req   = r_m_wr_req;
  assign bus.m_addr     = r_m_addr;
  assign bus.m_wdata    = r_m_wdata;
  assign bus.m_abort    = r_m_abort;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_req_arbiter
//  Description : Self-checking bench for axi_lite_req_arbiter. A
//                transaction-level model (pending-request mask, priority
//                pointer, per-requester payloads) predicts the winner, the
//                number of BUSY cycles and the response of each transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 32;
  localparam int TMO     = 16;

  logic clk;
  logic reset;

  axi_lite_req_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

  axi_lite_req_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Requester-side model state
  logic [NUM_REQ-1:0] tb_req;
  logic [31:0]        a_addr  [NUM_REQ];
  logic [DW-1:0]      a_wdata [NUM_REQ];
  logic               a_wr    [NUM_REQ];
  int                 ptr;

  function automatic int pick(input logic [NUM_REQ-1:0] req, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic arm(input int i);
    a_addr[i]  = $urandom;
    a_wdata[i] = $urandom;
    a_wr[i]    = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i]            = tb_req[i];
      bus.req_write[i]            = a_wr[i];
      bus.req_addr[32*i +: 32]    = a_addr[i];
      bus.req_wdata[DW*i +: DW]   = a_wdata[i];
    end
  endtask

  // One full transaction starting from IDLE. done_at = BUSY cycle index
  // (0-based) at which m_done is pulsed; negative means never.
  task automatic do_txn(input int done_at, input logic err_in, input logic [DW-1:0] rd_in,
                        input bit hold, output int w);
    logic [NUM_REQ-1:0] oh;
    logic               tmo;
    int                 nbusy;
    logic [DW-1:0]      exp_rd;
    logic               exp_err;
    w     = pick(tb_req, ptr);
    oh    = NUM_REQ'(1) << w;
    tmo   = (done_at < 0) || (done_at >= TMO);
    nbusy = tmo ? TMO : done_at + 1;
    drive_reqs();
    bus.m_done = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== oh) begin errors++; $display("FAIL req_ready: got %b expected %b", bus.req_ready, oh); end
    checks++; if (bus.m_wr_req !== a_wr[w] || bus.m_rd_req !== !a_wr[w]) begin errors++; $display("FAIL m_req: got rd=%b wr=%b expected wr=%b", bus.m_rd_req, bus.m_wr_req, a_wr[w]); end
    checks++; if (bus.m_addr !== a_addr[w]) begin errors++; $display("FAIL m_addr: got %h expected %h", bus.m_addr, a_addr[w]); end
    checks++; if (bus.m_wdata !== a_wdata[w]) begin errors++; $display("FAIL m_wdata: got %h expected %h", bus.m_wdata, a_wdata[w]); end
    if (!hold) tb_req[w] = 1'b0;
    drive_reqs();
    for (int j = 0; j < nbusy; j++) begin
      if (j > 0) begin
        checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL req_ready_pulse: got %b expected 0 at busy %0d", bus.req_ready, j); end
        checks++; if (bus.m_addr !== a_addr[w] || bus.m_wr_req !== a_wr[w] || bus.m_rd_req !== !a_wr[w]) begin errors++; $display("FAIL busy_hold: got addr=%h wr=%b rd=%b expected addr=%h wr=%b", bus.m_addr, bus.m_wr_req, bus.m_rd_req, a_addr[w], a_wr[w]); end
      end
      checks++; if (bus.resp_valid !== '0 || bus.m_abort !== 1'b0) begin errors++; $display("FAIL busy_early_resp: got resp_valid=%b abort=%b expected 0 at busy %0d", bus.resp_valid, bus.m_abort, j); end
      bus.m_done  = (j == done_at);
      bus.m_err   = (j == done_at) ? err_in : 1'($urandom_range(0, 1));
      bus.m_rdata = (j == done_at) ? rd_in : DW'($urandom);
      @(posedge clk); #1;
    end
    // RESP cycle: a stray m_done here must be ignored
    bus.m_done = 1'($urandom_range(0, 1));
    bus.m_err  = 1'($urandom_range(0, 1));
    exp_rd  = (tmo || a_wr[w]) ? '0 : rd_in;
    exp_err = tmo ? 1'b1 : err_in;
    checks++; if (bus.resp_valid !== oh) begin errors++; $display("FAIL resp_valid: got %b expected %b", bus.resp_valid, oh); end
    checks++; if (bus.resp_rdata !== exp_rd) begin errors++; $display("FAIL resp_rdata: got %h expected %h", bus.resp_rdata, exp_rd); end
    checks++; if (bus.resp_err !== exp_err) begin errors++; $display("FAIL resp_err: got %b expected %b", bus.resp_err, exp_err); end
    checks++; if (bus.m_abort !== tmo) begin errors++; $display("FAIL m_abort: got %b expected %b", bus.m_abort, tmo); end
    checks++; if (bus.m_rd_req !== 1'b0 || bus.m_wr_req !== 1'b0) begin errors++; $display("FAIL resp_mreq: got rd=%b wr=%b expected 0", bus.m_rd_req, bus.m_wr_req); end
    ptr = (w + 1) % NUM_REQ;
    @(posedge clk); #1;
    bus.m_done = 1'b0;
    bus.m_err  = 1'b0;
    checks++; if (bus.resp_valid !== '0 || bus.resp_rdata !== '0 || bus.resp_err !== 1'b0 || bus.m_abort !== 1'b0 || bus.req_ready !== '0) begin
      errors++; $display("FAIL idle_outputs: got rv=%b rd=%h re=%b ab=%b rr=%b expected all 0", bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.m_abort, bus.req_ready);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (bus.req_ready !== '0 || bus.resp_valid !== '0 || bus.resp_rdata !== '0 || bus.resp_err !== 1'b0 ||
        bus.m_rd_req !== 1'b0 || bus.m_wr_req !== 1'b0 || bus.m_addr !== '0 || bus.m_wdata !== '0 || bus.m_abort !== 1'b0) begin
      errors++;
      $display("FAIL %s: got rr=%b rv=%b rd=%h re=%b mrd=%b mwr=%b ma=%h mw=%h ab=%b expected all 0", tag,
               bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.m_rd_req, bus.m_wr_req,
               bus.m_addr, bus.m_wdata, bus.m_abort);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tb_req = '1;
    for (int i = 0; i < NUM_REQ; i++) arm(i);
    drive_reqs();
    bus.m_done = 1'b1; bus.m_err = 1'b1; bus.m_rdata = DW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    tb_req = '0;
    drive_reqs();
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("idle_no_req_with_m_done");
    bus.m_done = 1'b0; bus.m_err = 1'b0;
    @(posedge clk); #1;
    check_all_zero("idle_quiet");
    ptr = 0;
  endtask

  task automatic test_round_robin();
    int w;
    tb_req = '1;
    for (int i = 0; i < NUM_REQ; i++) arm(i);
    for (int t = 0; t < 8; t++) do_txn(1, 1'b0, DW'($urandom), 1'b1, w);
    tb_req = '0;
    drive_reqs();
  endtask

  task automatic test_single_read();
    int w;
    tb_req = 4'b0010;
    a_addr[1] = 32'h4000_0010; a_wdata[1] = DW'($urandom); a_wr[1] = 1'b0;
    do_txn(3, 1'b0, 32'hDEAD_BEEF, 1'b0, w);
  endtask

  task automatic test_write_error();
    int w;
    tb_req = 4'b1000;
    a_addr[3] = 32'h0000_0020; a_wdata[3] = 32'h1234_5678; a_wr[3] = 1'b1;
    do_txn(2, 1'b1, DW'($urandom), 1'b0, w);
  endtask

  task automatic test_timeout();
    int w;
    tb_req = 4'b0001;
    arm(0);
    do_txn(-1, 1'b0, '0, 1'b0, w);
    tb_req = 4'b0100;
    arm(2);
    do_txn(0, 1'b0, DW'($urandom), 1'b0, w);
  endtask

  task automatic test_done_at_timeout_edge();
    int w;
    for (int e = 0; e < 2; e++) begin
      tb_req = NUM_REQ'(1) << $urandom_range(0, NUM_REQ - 1);
      for (int i = 0; i < NUM_REQ; i++) arm(i);
      do_txn(TMO - 1, 1'(e), DW'($urandom), 1'b0, w);
    end
  endtask

  task automatic test_reset_mid_busy();
    int w;
    // Leave the priority pointer at 3 so a stale pointer would pick 3, not 2.
    tb_req = 4'b0100;
    arm(2);
    do_txn(0, 1'b0, DW'($urandom), 1'b0, w);
    tb_req = 4'b0001;
    arm(0);
    drive_reqs();
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rst_mid_grant: got %b expected 0001", bus.req_ready); end
    tb_req = 4'b1100;
    arm(2); arm(3);
    drive_reqs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset_mid_busy");
    reset = 1'b1;
    ptr = 0;
    for (int k = 0; k < 3; k++) begin
      // Dropped transaction must never respond; grant of 2 happens inside do_txn.
      if (k == 0) begin
        checks++; if (bus.resp_valid !== '0) begin errors++; $display("FAIL rst_no_resp: got %b expected 0", bus.resp_valid); end
      end
    end
    do_txn(1, 1'b0, DW'($urandom), 1'b0, w);
    tb_req = '0;
    drive_reqs();
  endtask

  task automatic test_random();
    int w;
    logic [NUM_REQ-1:0] nw;
    for (int t = 0; t < 24; t++) begin
      nw = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) if (nw[i] && !tb_req[i]) arm(i);
      tb_req = tb_req | nw;
      if ($urandom_range(0, 3) == 0) tb_req[$urandom_range(0, NUM_REQ - 1)] = 1'b0;
      if (tb_req == '0) begin
        tb_req[t % NUM_REQ] = 1'b1;
        arm(t % NUM_REQ);
      end
      do_txn($urandom_range(0, TMO + 3), 1'($urandom_range(0, 1)), DW'($urandom), 1'b0, w);
    end
    tb_req = '0;
    drive_reqs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset       = 1'b0;
    tb_req      = '0;
    ptr         = 0;
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.m_rdata = '0; bus.m_done = 1'b0; bus.m_err = 1'b0;
    test_reset();
    test_round_robin();
    test_single_read();
    test_write_error();
    test_timeout();
    test_done_at_timeout_edge();
    test_reset_mid_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_req_arbiter.md
Name: axi_lite_req_arbiter

Overview:
- Shares one AXI4-Lite master transaction port among NUM_REQ on-chip requesters, e.g. Ethernet MAC register, DMA descriptor and statistics engines.
- Accepts one request at a time by round-robin arbitration and drives it onto the downstream master's request/address/data inputs.
- Waits for completion, then returns read data and status to the winning requester.
- A watchdog aborts transactions that never complete.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, data width of the requester and master ports
- TIMEOUT, 1024, cycles allowed in BUSY before abort; 0 disables the watchdog

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request pending, held until req_ready
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*32  flat address bus; requester i uses bits [32i+31:32i]
- req_wdata  in  NUM_REQ*DATA_WIDTH  flat write-data bus
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse
- resp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  read data, valid with resp_valid
- resp_err  out  1  error or timeout, valid with resp_valid
- m_rd_req  out  1  read request to master
- m_wr_req  out  1  write request to master
- m_addr  out  32  transaction address
- m_wdata  out  DATA_WIDTH  write data
- m_rdata  in  DATA_WIDTH  read data from master
- m_done  in  1  one-cycle completion strobe from master
- m_err  in  1  nonzero RRESP/BRESP, qualified by m_done
- m_abort  out  1  one-cycle abort pulse on timeout

Behaviour:
- One clock, clk; reset is synchronous and active-low.
- Every output is registered. While reset is low, all outputs are 0, the state is IDLE, rr_ptr = 0 and the timeout count = 0.
- Reset mid-transaction drops the in-flight transaction; no resp_valid is issued for it.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any req_valid bit is set, pick the winner as the first set bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - At the clock edge, latch the winner's index, write flag, address and wdata, then go to BUSY.
  - With no requests, stay in IDLE and hold all outputs at 0.
- BUSY:
  - m_rd_req or m_wr_req (per the latched write flag), m_addr and m_wdata are held constant for the whole state.
  - req_ready[winner] = 1 in the first BUSY cycle only.
  - The timeout count increments each BUSY cycle.
  - On m_done: capture m_rdata (forced to 0 for writes) and m_err, then go to RESP.
  - Else, if TIMEOUT != 0 and the count reaches TIMEOUT-1: go to RESP with err = 1 and rdata = 0.
  - m_done in the same cycle as the timeout terminal count: m_done wins.
- RESP (exactly 1 cycle):
  - Outputs: resp_valid[winner] = 1, resp_rdata and resp_err from the captured values, and m_abort = 1 only if the exit was by timeout.
  - m_rd_req and m_wr_req = 0.
  - rr_ptr <= (winner+1) mod NUM_REQ; the timeout count clears; next state is IDLE.
- Latency:
  - req_valid sampled high in IDLE at cycle 0: m_*_req and req_ready high in cycle 1.
  - m_done in cycle k: resp_valid in cycle k+1, IDLE in cycle k+2.
  - Minimum is 3 cycles per transaction plus downstream latency.
- Requester rules:
  - A requester may deassert req_valid on the edge after req_ready.
  - A req_valid still high after req_ready is treated as a new request.
  - A requester dropping req_valid before grant is legal; nothing is latched for it.
- Fairness: after serving requester i, i has lowest priority. With all requesters continuously requesting, service order is 0, 1, ..., N-1, 0, ...
- m_done or m_err outside BUSY is ignored.
- resp_rdata and resp_err are 0 whenever resp_valid is 0.

Decomposition:
- Shared package axi_lite_arb_pkg:
  - state encodings (IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2)
  - the clog2 function for the index and pointer widths
  - OKAY/SLVERR response constants
- One natural sub-module, axi_lite_rr_pick:
  - combinational round-robin picker
  - inputs: req vector and rr_ptr
  - outputs: winner index and any_req

Test Plan:
1. Single read: req_valid = 4'b0010, addr 0x4000_0010; master returns m_done with m_rdata 0xDEADBEEF on the 4th BUSY cycle -> req_ready = 4'b0010 in cycle 1, m_addr = 0x4000_0010, resp_valid = 4'b0010 with rdata 0xDEADBEEF and err 0 one cycle after m_done.
2. Round-robin: all 4 requesters held valid for 8 transactions, master done after 2 cycles -> grant order 0,1,2,3,0,1,2,3; no requester granted twice before the others.
3. Write with error: requester 3 writes 0x1234_5678 to 0x0000_0020; m_done with m_err = 1 -> m_wr_req = 1, m_wdata = 0x1234_5678, resp_valid[3] with resp_err = 1 and resp_rdata = 0.
4. Timeout: TIMEOUT = 16, m_done never asserted -> exactly 16 BUSY cycles, then m_abort and resp_valid[0] with err = 1 for one cycle; the next request is accepted normally.
5. Done at timeout edge: m_done asserted on the terminal BUSY cycle -> resp_err = m_err, m_abort = 0.
6. Reset mid-BUSY: reset low for 1 cycle during BUSY -> all outputs 0 and no resp_valid; after release, a pending requester 2 is the one granted next, with rr_ptr = 0.
